// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter shared definitions: CDB packet
// layout and the default functional-unit count.
package cdb_arbiter_pkg;

  localparam int CDB_NUM_SRC = 4;
  localparam int CDB_REG_W   = 6;
  localparam int CDB_DATA_W  = 32;

  typedef struct packed {
    logic                  valid;
    logic [CDB_REG_W-1:0]  completing_reg;
    logic [CDB_DATA_W-1:0] result;
  } CDB_REG_PACKET;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result-collection bus between functional units
// and the CDB arbiter; slave side is the arbiter.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = CDB_NUM_SRC
);

  CDB_REG_PACKET      fu_result [NUM_SRC];
  logic [NUM_SRC-1:0] fu_ready;
  logic               squash;
  CDB_REG_PACKET      cdb_out;

  modport master (
    output fu_result,
    output squash,
    input  fu_ready,
    input  cdb_out
  );

  modport slave (
    input  fu_result,
    input  squash,
    output fu_ready,
    output cdb_out
  );

endinterface

// File: rtl/cdb_arb_picker.sv
// Rotating first-set picker: scans req starting at
// start, wraps, returns a one-hot grant.
module cdb_arb_picker #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  grant,
  output logic          gnt_valid
);

  // first requester at or after start, wrapping
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    grant     = '0;
    gnt_valid = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, start} + (IW+1)'(k);
      if (sum >= (IW+1)'(N))
        sum = sum - (IW+1)'(N);
      idx = sum[IW-1:0];
      if (!gnt_valid && req[idx]) begin
        grant[idx] = 1'b1;
        gnt_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding slot per unit, one broadcast
// per cycle. CDB_ARB_RR_EN selects round-robin priority.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = CDB_NUM_SRC
) (
  input logic          clock,
  input logic          reset,
  cdb_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] hold_valid_q;
  logic [NUM_SRC-1:0] hold_valid_d;
  CDB_REG_PACKET      hold_pkt_q [NUM_SRC];
  CDB_REG_PACKET      hold_pkt_d [NUM_SRC];
  CDB_REG_PACKET      cdb_q;
  CDB_REG_PACKET      cdb_d;

  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] ready;
  logic [NUM_SRC-1:0] accept;
  logic               gnt_valid;
  logic [IW-1:0]      start;
  logic [IW-1:0]      gnt_idx;

`ifdef CDB_ARB_RR_EN
  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] rr_ptr_d;
  assign start = rr_ptr_q;
`else
  assign start = '0;
`endif

  cdb_arb_picker #(
    .N(NUM_SRC)
  ) u_picker (
    .req      (hold_valid_q),
    .start    (start),
    .grant    (grant),
    .gnt_valid(gnt_valid)
  );

  // ready depends on state and squash only
  assign ready = ~hold_valid_q | grant
               | {NUM_SRC{bus.squash}};

  assign bus.fu_ready = ready;
  assign bus.cdb_out  = cdb_q;

  // one-hot grant to index
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (grant[i])
        gnt_idx = IW'(i);
  end

  // slot refill beats grant clear; squash empties all
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      accept[i] = bus.fu_result[i].valid & ready[i];
      hold_pkt_d[i] = accept[i] ? bus.fu_result[i]
                                : hold_pkt_q[i];
      if (bus.squash)
        hold_valid_d[i] = 1'b0;
      else if (accept[i])
        hold_valid_d[i] = 1'b1;
      else
        hold_valid_d[i] = hold_valid_q[i] & ~grant[i];
    end
  end

  // winner goes out as-is; payload held when idle
  always_comb begin
    cdb_d       = cdb_q;
    cdb_d.valid = 1'b0;
    if (!bus.squash && gnt_valid)
      cdb_d = hold_pkt_q[gnt_idx];
  end

  // slot and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_valid_q <= '0;
      cdb_q        <= '0;
      for (int i = 0; i < NUM_SRC; i++)
        hold_pkt_q[i] <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      cdb_q        <= cdb_d;
      for (int i = 0; i < NUM_SRC; i++)
        hold_pkt_q[i] <= hold_pkt_d[i];
    end
  end

`ifdef CDB_ARB_RR_EN
  // pointer moves past the winner; frozen on squash
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (!bus.squash && gnt_valid) begin
      if (gnt_idx == IW'(NUM_SRC-1))
        rr_ptr_d = '0;
      else
        rr_ptr_d = gnt_idx + IW'(1);
    end
  end

  // round-robin pointer register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      rr_ptr_q <= '0;
    else
      rr_ptr_q <= rr_ptr_d;
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter; expected broadcasts
// are queued at stimulus time, popped on cdb_out.valid.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  cdb_arbiter_if #(.NUM_SRC(N)) bus ();

  cdb_arbiter #(
    .NUM_SRC(N)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  CDB_REG_PACKET src_q [N][$];
  CDB_REG_PACKET sb [$];
  CDB_REG_PACKET mon_exp;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic CDB_REG_PACKET mk(input int r,
                                       input int d);
    CDB_REG_PACKET p;
    p.valid          = 1'b1;
    p.completing_reg = CDB_REG_W'(r);
    p.result         = CDB_DATA_W'(d);
    return p;
  endfunction

  task automatic send(input int s, input int r,
                      input int d);
    src_q[s].push_back(mk(r, d));
  endtask

  task automatic expect_pkt(input int r, input int d);
    sb.push_back(mk(r, d));
  endtask

  // advance into the next cycle, land mid-cycle
  task automatic next_cycle(input logic sq);
    @(posedge clock);
    #1 bus.squash = sq;
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b0;
    bus.squash = 1'b0;
    #1;
    check("rst_cdb", 64'(bus.cdb_out), 64'(0));
    check("rst_ready", 64'(bus.fu_ready), 64'(4'hF));
    repeat (2) @(posedge clock);
    @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
  endtask

  // producer model: hold until accepted, then advance
  initial begin : drv
    logic [N-1:0]  acc;
    logic [N-1:0]  stall;
    CDB_REG_PACKET prev [N];
    acc   = '0;
    stall = '0;
    for (int i = 0; i < N; i++) begin
      bus.fu_result[i] = '0;
      prev[i] = '0;
    end
    forever begin
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
        if (stall[i])
          check("hold_stable", 64'(bus.fu_result[i]),
                64'(prev[i]));
        acc[i]   = bus.fu_result[i].valid
                 & bus.fu_ready[i];
        stall[i] = bus.fu_result[i].valid
                 & ~bus.fu_ready[i];
        prev[i]  = bus.fu_result[i];
      end
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i])
          void'(src_q[i].pop_front());
        if (src_q[i].size() > 0)
          bus.fu_result[i] = src_q[i][0];
        else
          bus.fu_result[i] = '0;
      end
    end
  end

  // broadcast monitor
  always @(negedge clock) begin
    if (reset === 1'b1 && bus.cdb_out.valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_bcast", 64'(bus.cdb_out), 64'(0));
      end else begin
        mon_exp = sb.pop_front();
        check("bcast", 64'(bus.cdb_out), 64'(mon_exp));
      end
    end
  end

  initial begin : main
    bus.squash = 1'b0;

    // single request
    do_reset();
    send(2, 7, 32'h0000_1234);
    expect_pkt(7, 32'h0000_1234);
    for (int c = 0; c < 4; c++) begin
      next_cycle(1'b0);
      check("single_rdy2", 64'(bus.fu_ready[2]), 64'(1));
      check("single_valid", 64'(bus.cdb_out.valid),
            64'(c == 2));
    end

    // contention, one packet each
    do_reset();
    for (int s = 0; s < N; s++) begin
      send(s, s + 1, 32'h100 + s);
      expect_pkt(s + 1, 32'h100 + s);
    end
    for (int c = 0; c < 7; c++) begin
      next_cycle(1'b0);
      check("cont_valid", 64'(bus.cdb_out.valid),
            64'(c >= 2 && c <= 5));
    end

    // backpressure / starvation
    do_reset();
    for (int k = 0; k < 4; k++)
      send(0, 10 + k, 32'hA0 + k);
    send(1, 20, 32'hB0);
    send(1, 21, 32'hB1);
`ifdef CDB_ARB_RR_EN
    expect_pkt(10, 32'hA0);
    expect_pkt(20, 32'hB0);
    expect_pkt(11, 32'hA1);
    expect_pkt(21, 32'hB1);
    expect_pkt(12, 32'hA2);
    expect_pkt(13, 32'hA3);
`else
    for (int k = 0; k < 4; k++)
      expect_pkt(10 + k, 32'hA0 + k);
    expect_pkt(20, 32'hB0);
    expect_pkt(21, 32'hB1);
`endif
    for (int c = 0; c < 10; c++) begin
      next_cycle(1'b0);
      if (c == 1)
        check("bp_rdy1", 64'(bus.fu_ready[1]), 64'(0));
    end

    // squash with three slots full
    do_reset();
    send(0, 30, 32'h300);
    send(1, 31, 32'h301);
    send(2, 32, 32'h302);
    next_cycle(1'b0);
    send(3, 33, 32'h303);
    next_cycle(1'b1);
    check("sq_rdy_c1", 64'(bus.fu_ready), 64'(4'hF));
    next_cycle(1'b0);
    check("sq_valid_c2", 64'(bus.cdb_out.valid), 64'(0));
    check("sq_rdy_c2", 64'(bus.fu_ready), 64'(4'hF));
    for (int c = 3; c < 7; c++) begin
      next_cycle(1'b0);
      check("sq_valid", 64'(bus.cdb_out.valid), 64'(0));
    end

    // async reset mid-stream
    do_reset();
    send(0, 40, 32'h400);
    send(1, 41, 32'h401);
    send(2, 42, 32'h402);
    expect_pkt(40, 32'h400);
    for (int c = 0; c < 3; c++)
      next_cycle(1'b0);
    check("arst_pre", 64'(bus.cdb_out.valid), 64'(1));
    #1 reset = 1'b0;
    #1;
    check("arst_valid", 64'(bus.cdb_out.valid), 64'(0));
    check("arst_rdy", 64'(bus.fu_ready), 64'(4'hF));
    #1 reset = 1'b1;
    for (int c = 3; c < 7; c++) begin
      next_cycle(1'b0);
      check("arst_idle", 64'(bus.cdb_out.valid), 64'(0));
    end
    send(1, 43, 32'h403);
    expect_pkt(43, 32'h403);
    for (int c = 7; c < 11; c++) begin
      next_cycle(1'b0);
      check("arst_new", 64'(bus.cdb_out.valid),
            64'(c == 9));
    end

    // streaming from src3
    do_reset();
    for (int k = 0; k < 10; k++) begin
      send(3, 50 + k, 32'h5000 + k);
      expect_pkt(50 + k, 32'h5000 + k);
    end
    for (int c = 0; c < 13; c++) begin
      next_cycle(1'b0);
      check("stream_rdy3", 64'(bus.fu_ready[3]), 64'(1));
      check("stream_valid", 64'(bus.cdb_out.valid),
            64'(c >= 2 && c <= 11));
    end

    repeat (3) next_cycle(1'b0);
    check("sb_drain", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Collects completed results from NUM_SRC functional units (ALU, multiplier, load unit, …), buffers at most one result per unit, and broadcasts one winner per cycle on the common data bus. It is the receiving end of every unit's CDB_REG_PACKET output and the sole driver of the CDB seen by the reservation stations, ROB and map table. It applies backpressure per source and drops all buffered results on a squash.

## Interface
- NUM_SRC, default 4: number of functional-unit result ports (≥2).
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- fu_result  in  CDB_REG_PACKET [NUM_SRC]  per-unit result; `.valid` is the request.
- fu_ready  out  [NUM_SRC-1:0]  the unit's slot accepts a packet this cycle.
- squash  in  1  mispredict flush; discards held and incoming results.
- cdb_out  out  CDB_REG_PACKET  registered broadcast; `.valid`, `.completing_reg`, `.result`.

## Operation
- One holding slot per source: `hold_valid[i]`, `hold_pkt[i]`.
- Accept when `fu_result[i].valid && fu_ready[i]`. The packet is written into slot i at the edge.
- `fu_ready[i] = !hold_valid[i] || grant[i] || squash`. It is computed only from registered state and squash, so there is no combinational path from `fu_result`.
- The arbiter selects one winner among the slots with `hold_valid` set. The winner's packet is registered into cdb_out with valid=1. Its slot is cleared unless it is refilled at the same edge; a refill takes priority over the clear.
- If no slot is valid, `cdb_out.valid` goes to 0 next cycle. `completing_reg` and `result` hold their last value and must be ignored when valid=0.
- Squash in cycle t:
  - At the edge ending cycle t, all hold_valid are cleared and `cdb_out.valid` is set to 0.
  - Packets presented in cycle t are accepted and dropped.
  - No grant takes effect.
  - The arbitration pointer is unchanged.
- Packets are forwarded unmodified. No field is altered and none is filtered, including `completing_reg == 0`.
- Each accepted packet is broadcast exactly once unless it is squashed. There is no loss and no duplication.
- Producers hold `fu_result[i]` stable while `fu_ready[i]=0`. This is a checked bench assertion, not something the block enforces.

## Timing
- Reset (async assert, any time): `hold_valid` = 0, `cdb_out` = all-zero packet (valid=0), rr pointer = 0. `fu_ready` = all ones while in reset.
- Latency: a packet accepted at the edge ending cycle t is eligible in cycle t+1. If granted, it appears on cdb_out during cycle t+2. The minimum is 2 cycles.
- Throughput: one broadcast per cycle in aggregate. A single uncontended source can issue every cycle.
- Worst-case wait with round-robin: NUM_SRC−1 grants to other sources.
- Simultaneous squash and grant: the squash wins and nothing is broadcast.
- Reset deasserted mid-stream: no stale packet is emitted. The first valid broadcast requires a new accept.

## Configuration
- `CDB_ARB_RR_EN` defined: round-robin.
  - Priority starts at `rr_ptr`.
  - After a grant to i, `rr_ptr <= (i+1) mod NUM_SRC`.
  - With no grant, `rr_ptr` is unchanged.
- Undefined: fixed priority, lowest index wins. `rr_ptr` is absent and source 0 may starve the others.

## Structure
- CDB_REG_PACKET is already shared. Add the constant `CDB_NUM_SRC` (default for NUM_SRC) to the shared definitions header.
- One combinational sub-module, `cdb_arb_picker`: input request vector, start index; outputs one-hot grant and grant-valid. With the macro undefined it is instantiated with start index 0.
- Slots, pointer and output register live in cdb_arbiter.

## Test plan
- Single request: after reset, src2 presents reg 7 / 0x0000_1234 in cycle 0 → cdb_out valid, reg 7, 0x1234 in cycle 2 only; `fu_ready[2]` stays 1.
- Contention: src0–3 each present one packet (regs 1–4) in cycle 0.
  - RR: broadcasts reg 1, 2, 3, 4 in cycles 2–5.
  - Fixed, with src0 re-requesting every cycle: only src0 results appear until src0 stops.
- Backpressure: src1 slot held and losing arbitration, new packet presented → `fu_ready[1]`=0. The packet is accepted on the grant cycle and each packet is broadcast once, in order.
- Squash: three slots full, squash for one cycle → next cycle `cdb_out.valid`=0 and all `fu_ready`=1. None of the three packets is ever broadcast, and a packet presented during the squash is also dropped.
- Async reset mid-stream: reset pulsed low between edges with slots full → `cdb_out.valid` is 0 immediately. Nothing is broadcast after release until a new accept, with first output 2 cycles later.
- Streaming: src3 alone presents a new packet every cycle for 10 cycles → 10 consecutive broadcasts starting cycle 2, `fu_ready[3]` constantly 1.
